// File: rtl/simplebus_master.sv
// simplebus_master: Wishbone-pipelined slave that bridges 32-bit loads/stores
// onto the byte-serial simplebus, plus the IRQ synchroniser and pin-mux select.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus quiet, divider parked, ready to accept a request
// SEND     | driving CMD/ADR(/DATA) bytes, one per bus period
// WAIT_ACK | polling the inbound byte for the slave's 0x01 response
// RECV     | collecting four read-data bytes, most significant first
// DONE     | one-cycle Wishbone ack, then back to IDLE
module simplebus_master #(
    parameter int CLK_DIV = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [29:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_stall_o,
    input  logic        enable,
    output logic        simplebus_enabled,
    output logic        simplebus_clk,
    output logic [7:0]  simplebus_bus_out,
    output logic        simplebus_parity_out,
    input  logic [7:0]  simplebus_bus_in,
    input  logic        simplebus_parity_in,
    input  logic        simplebus_irq,
    output logic        irq_o,
    output logic        err_o,
    input  logic        err_clr
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, RECV, DONE} state_t;

    state_t        state, state_next;
    logic [DW-1:0] div_cnt;
    logic          bus_active, div_wrap, fall_tick, rise_tick;
    logic          accept, in_par_ok;
    logic [3:0]    byte_idx, last_idx;
    logic [29:0]   lat_adr;
    logic [31:0]   lat_dat;
    logic [3:0]    lat_sel;
    logic          lat_we;
    logic [7:0]    to_cnt;
    logic [1:0]    rx_cnt;
    logic [23:0]   rx_shift;
    logic          rx_err;
    logic          cyc_lost;
    logic          irq_meta;
    logic          set_err, load_rdata;
    logic [31:0]   rdata_next;

    // Byte idx of the outbound frame: CMD, four ADR bytes, then DATA for writes.
    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [29:0] adr,
                                              input logic [31:0] dat,
                                              input logic [3:0]  sel,
                                              input logic        we);
        case (idx)
            4'd0:    frame_byte = {2'b00, sel, we, 1'b1};
            4'd1:    frame_byte = {2'b00, adr[29:24]};
            4'd2:    frame_byte = adr[23:16];
            4'd3:    frame_byte = adr[15:8];
            4'd4:    frame_byte = adr[7:0];
            4'd5:    frame_byte = dat[31:24];
            4'd6:    frame_byte = dat[23:16];
            4'd7:    frame_byte = dat[15:8];
            4'd8:    frame_byte = dat[7:0];
            default: frame_byte = 8'h00;
        endcase
    endfunction

    assign bus_active = (state == SEND) || (state == WAIT_ACK) || (state == RECV);
    assign div_wrap   = bus_active && (div_cnt == DIV_LAST);
    assign fall_tick  = div_wrap && simplebus_clk;
    assign rise_tick  = div_wrap && !simplebus_clk;

    // Stall is only ever low in IDLE, so acceptance needs no stall term.
    assign accept     = (state == IDLE) && wb_cyc_i && wb_stb_i;
    assign in_par_ok  = (simplebus_parity_in == ^simplebus_bus_in);
    assign last_idx   = lat_we ? 4'd8 : 4'd4;

    assign wb_stall_o           = (state != IDLE);
    assign wb_ack_o             = (state == DONE) && !cyc_lost && wb_cyc_i;
    assign simplebus_parity_out = ^simplebus_bus_out;

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode plus the error/read-data strobes that go with each exit.
    always_comb begin
        state_next = state;
        set_err    = 1'b0;
        load_rdata = 1'b0;
        rdata_next = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (enable) begin
                        state_next = SEND;
                    end else begin
                        state_next = DONE;
                        load_rdata = 1'b1;
                        rdata_next = '1;
                    end
                end
            end
            SEND: begin
                if (fall_tick && (byte_idx == last_idx)) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (rise_tick) begin
                    if (simplebus_bus_in == 8'h00) begin
                        if (to_cnt == TO_LAST) begin
                            set_err    = 1'b1;
                            state_next = DONE;
                            load_rdata = 1'b1;
                            rdata_next = '1;
                        end
                    end else if ((simplebus_bus_in == 8'h01) && in_par_ok) begin
                        if (lat_we) begin
                            state_next = DONE;
                            load_rdata = 1'b1;
                            rdata_next = '0;
                        end else begin
                            state_next = RECV;
                        end
                    end else begin
                        set_err    = 1'b1;
                        state_next = DONE;
                        load_rdata = 1'b1;
                        rdata_next = '1;
                    end
                end
            end
            RECV: begin
                if (rise_tick) begin
                    if (!in_par_ok) set_err = 1'b1;
                    if (rx_cnt == 2'd3) begin
                        state_next = DONE;
                        load_rdata = 1'b1;
                        rdata_next = (rx_err || !in_par_ok) ? '1 : {rx_shift, simplebus_bus_in};
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus clock divider; parked with the clock low whenever no frame is in flight.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !bus_active) begin
            div_cnt       <= '0;
            simplebus_clk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt       <= '0;
            simplebus_clk <= ~simplebus_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Outbound frame: byte 0 goes out at acceptance, later bytes on fall ticks.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            simplebus_bus_out <= '0;
            byte_idx          <= '0;
            lat_adr           <= '0;
            lat_dat           <= '0;
            lat_sel           <= '0;
            lat_we            <= 1'b0;
        end else if (accept && enable) begin
            lat_adr           <= wb_adr_i;
            lat_dat           <= wb_dat_i;
            lat_sel           <= wb_sel_i;
            lat_we            <= wb_we_i;
            byte_idx          <= '0;
            simplebus_bus_out <= frame_byte(4'd0, wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i);
        end else if ((state == SEND) && fall_tick) begin
            if (byte_idx == last_idx) begin
                simplebus_bus_out <= 8'h00;
            end else begin
                byte_idx          <= byte_idx + 4'd1;
                simplebus_bus_out <= frame_byte(byte_idx + 4'd1, lat_adr, lat_dat, lat_sel, lat_we);
            end
        end
    end

    // Response side: idle-period count while waiting, byte shifter while receiving.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt   <= '0;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_err   <= 1'b0;
        end else begin
            case (state)
                SEND: begin
                    to_cnt <= '0;
                    rx_cnt <= '0;
                    rx_err <= 1'b0;
                end
                WAIT_ACK: begin
                    if (rise_tick && (simplebus_bus_in == 8'h00)) to_cnt <= to_cnt + 8'd1;
                end
                RECV: begin
                    if (rise_tick) begin
                        rx_shift <= {rx_shift[15:0], simplebus_bus_in};
                        rx_cnt   <= rx_cnt + 2'd1;
                        if (!in_par_ok) rx_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A requester that drops cyc mid-frame loses its ack and its read data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (state == IDLE) || (state == DONE)) cyc_lost <= 1'b0;
        else if (!wb_cyc_i)                                  cyc_lost <= 1'b1;
    end

    // Read data register; holds between acks.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                                      wb_dat_o <= '0;
        else if (load_rdata && wb_cyc_i && !cyc_lost)      wb_dat_o <= rdata_next;
    end

    // Sticky error; a new error in the same cycle as err_clr wins.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)     err_o <= 1'b0;
        else if (set_err) err_o <= 1'b1;
        else if (err_clr) err_o <= 1'b0;
    end

    // Pin-mux select and two-flop IRQ synchroniser.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            simplebus_enabled <= 1'b0;
            irq_meta          <= 1'b0;
            irq_o             <= 1'b0;
        end else begin
            simplebus_enabled <= enable;
            irq_meta          <= simplebus_irq;
            irq_o             <= irq_meta;
        end
    end

endmodule

// File: doc/simplebus_master.md
Name: simplebus_master

Overview:
- Wishbone-pipelined slave that turns 32-bit CPU loads and stores into byte-serial frames on the external simplebus.
- Drives the simplebus_clk / bus_out / parity_out signals that the top-level wrapper muxes onto pins 16-34.
- Samples bus_in / parity_in for responses.
- Also synchronises the external IRQ pin, and owns the simplebus_enabled pin-mux select.

Parameters:
- CLK_DIV, 2: wb_clk_i cycles per simplebus_clk half-period (>=1); bus byte period T = 2*CLK_DIV cycles.
- TIMEOUT, 255: bus periods allowed in WAIT_ACK before abort (8-bit counter).

Ports:
- wb_clk_i input 1: sole clock.
- wb_rst_i input 1: reset, synchronous, active-high.
- wb_adr_i input 30: word address.
- wb_dat_i input 32: write data.
- wb_sel_i input 4: byte selects.
- wb_we_i input 1: write enable.
- wb_stb_i input 1: strobe.
- wb_cyc_i input 1: cycle.
- wb_ack_o output 1: one-cycle ack.
- wb_dat_o output 32: read data.
- wb_stall_o output 1: high whenever state != IDLE.
- enable input 1: control-register bit; driven out as simplebus_enabled.
- simplebus_enabled output 1: registered copy of enable, pin-mux select.
- simplebus_clk output 1: bus clock.
- simplebus_bus_out output 8: outbound byte.
- simplebus_parity_out output 1: even parity of bus_out (XOR of its 8 bits).
- simplebus_bus_in input 8: inbound byte.
- simplebus_parity_in input 1: inbound parity.
- simplebus_irq input 1: asynchronous external IRQ.
- irq_o output 1: IRQ after 2-flop synchroniser.
- err_o output 1: sticky error (timeout or parity).
- err_clr input 1: clears err_o.

Behaviour:
- Reset values:
  - All outputs 0, state IDLE, divider counter 0.
  - wb_stall_o is 0 in IDLE.
- Bus timing:
  - Divider runs only when state != IDLE; simplebus_clk is held 0 in IDLE.
  - Fall tick: counter wraps while clk is high. New byte/parity is driven on the fall tick.
  - Rise tick: counter wraps while clk is low. simplebus_bus_in and simplebus_parity_in are sampled on the rise tick.
- Frame sent MSB-byte-first on each send:
  - CMD byte = {2'b00, sel[3:0], we, 1'b1}.
  - Then ADR bytes {2'b00,adr[29:24]}, adr[23:16], adr[15:8], adr[7:0].
  - Writes only: then DATA bytes dat[31:24] .. dat[7:0].
  - Write frame = 9 bytes; read frame = 5 bytes.
  - bus_out returns to 0x00 (parity 0) after the last byte.
- States:
  - IDLE:
    - Accept when cyc&stb&!stall.
    - If enable=1, latch adr/dat/sel/we and go to SEND with byte index 0.
    - If enable=0, go to nothing: ack next cycle with wb_dat_o=32'hFFFF_FFFF and no bus activity.
  - SEND: one byte per T; after the last byte go to WAIT_ACK.
  - WAIT_ACK:
    - At each rise tick, check the sampled byte.
    - 0x00 means idle; increment the timeout counter.
    - 0x01 with good parity:
      - Write → DONE.
      - Read → RECV.
    - Any other nonzero byte, or a parity mismatch: set err_o, go to DONE with rdata = all-ones.
    - Counter reaches TIMEOUT: set err_o, go to DONE with rdata = all-ones.
  - RECV:
    - Shift 4 bytes, first = bits 31:24, one per rise tick.
    - A parity error on any byte sets err_o and forces rdata to all-ones, but all 4 bytes are still consumed.
    - Then go to DONE.
  - DONE:
    - Assert wb_ack_o for exactly one cycle, with wb_dat_o = rdata (0 for writes).
    - Return to IDLE, reset the divider, and drive simplebus_clk low.
- cyc dropped mid-transaction: the bus frame still completes; the ack is suppressed.
- enable changes: only affect acceptance in IDLE; simplebus_enabled tracks enable one cycle later regardless of state.
- wb_rst_i mid-transaction: immediate return to IDLE, no ack, bus_out=0, err_o cleared.
- err_o:
  - Sticky.
  - err_clr clears it.
  - err_clr and a new error in the same cycle: the set wins.
- wb_dat_o holds its last value when not acking.
- Single outstanding transaction only.

Test Plan:
- Write, CLK_DIV=1: adr=0x0000_0040, dat=0xDEADBEEF, sel=0xF. Stub acks 0x01 on its 2nd period.
  - Bus bytes: 0x3F,00,00,00,40,DE,AD,BE,EF, each with correct parity.
  - One-cycle ack, wb_dat_o=0, err_o=0.
- Read: adr=0x3FFFFFFF. Stub returns 0x01,12,34,56,78.
  - Address bytes: 0x3F,FF,FF,FF.
  - ack with wb_dat_o=0x12345678.
- Timeout, TIMEOUT=4: read with stub silent.
  - ack after exactly 4 idle periods following the frame.
  - wb_dat_o=0xFFFFFFFF, err_o=1. Then err_clr → err_o=0.
- Parity error: stub flips parity on the 3rd data byte.
  - All 4 bytes are consumed.
  - wb_dat_o=0xFFFFFFFF, err_o=1.
- enable=0: read request.
  - ack one cycle after acceptance, data 0xFFFFFFFF.
  - simplebus_clk stays 0.
- Reset and cyc drop:
  - wb_rst_i at 4th byte of a write → IDLE next cycle, bus_out=0, no ack.
  - cyc dropped during WAIT_ACK → frame completes, no ack, stall releases.
- IRQ: pulse simplebus_irq → irq_o follows 2 cycles later.
